// File: rtl/ecg_seq_pkg.sv
// Shared types and defaults for the ECG window sequencer: FSM states, beat tags, memory geometry.
package ecg_seq_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int N_SAMPLES_DEF = 187;
  localparam int N_VALID_DEF   = 144;
  localparam int ADDR_W_DEF    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic                  win_last;
    logic                  frame_last;
    logic [ADDR_W_DEF-1:0] win_idx;
  } beat_tag_t;

  function automatic int num_windows(input int len, input int kernel, input int stride);
    return (len - kernel) / stride + 1;
  endfunction

endpackage

// File: rtl/ecg_seq_skid_buf.sv
// Two-entry FIFO holding returned samples and their tags; zero-latency head, registered write.
// Pushes while full are dropped, pops while empty ignored; flush empties it in one cycle.
module ecg_seq_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign dout    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/ecg_window_sequencer.sv
// Streams overlapping KERNEL-sample windows from the sample memory; first beat 2 cycles after start,
// reads throttled so a 2-entry skid buffer absorbs stalls. ECG_SEQ_PAD_EN extends windows into padding.
module ecg_window_sequencer
  import ecg_seq_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int N_SAMPLES = N_SAMPLES_DEF,
  parameter int N_VALID   = N_VALID_DEF,
  parameter int KERNEL    = 5,
  parameter int STRIDE    = 1,
  parameter int ADDR_W    = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_win_last,
  output logic              out_frame_last,
  output logic [ADDR_W-1:0] win_idx
);

`ifdef ECG_SEQ_PAD_EN
  localparam int FRAME_LEN = N_SAMPLES;
`else
  localparam int FRAME_LEN = N_VALID;
`endif
  localparam int N_WIN     = num_windows(FRAME_LEN, KERNEL, STRIDE);
  localparam int LAST_BASE = (N_WIN - 1) * STRIDE;
  localparam int BUF_W     = DATA_W + $bits(beat_tag_t);

  state_t            state;
  logic [ADDR_W-1:0] k;
  logic [ADDR_W-1:0] win_base;
  logic [ADDR_W-1:0] win_cnt;
  beat_tag_t         rd_tag;
  beat_tag_t         ret_tag;
  beat_tag_t         out_tag;
  logic              ret_vld;

  logic [BUF_W-1:0]  buf_dout;
  logic [1:0]        buf_count;
  logic              buf_full;
  logic              buf_empty;
  logic              hs;
  logic              push;
  logic              pop;
  logic [2:0]        count_next;
  logic              last_issue;
  logic              issue;

  ecg_seq_skid_buf #(.W(BUF_W)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .flush (abort),
    .push  (push),
    .pop   (pop),
    .din   ({mem_data, ret_tag}),
    .dout  (buf_dout),
    .count (buf_count),
    .full  (buf_full),
    .empty (buf_empty)
  );

  // Returning data bypasses the buffer when it is empty, so the first beat needs no extra cycle.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_tag   = '0;
    if (!buf_empty) begin
      out_valid           = 1'b1;
      {out_data, out_tag} = buf_dout;
    end else if (ret_vld) begin
      out_valid = 1'b1;
      out_data  = mem_data;
      out_tag   = ret_tag;
    end
  end

  assign out_win_last   = out_tag.win_last;
  assign out_frame_last = out_tag.frame_last;
  assign win_idx        = out_tag.win_idx;

  assign hs         = out_valid && out_ready;
  assign pop        = hs && !buf_empty;
  assign push       = ret_vld && !buf_full && !(buf_empty && out_ready);
  assign count_next = 3'(buf_count) + 3'(push) - 3'(pop);
  assign last_issue = (win_base == ADDR_W'(LAST_BASE)) && (k == ADDR_W'(KERNEL - 1));

  // A new read lands two cycles out; it must still fit beside buffered data and the read already on the bus.
  assign issue = !abort && ((state == IDLE && start) || state == FETCH)
                 && ((count_next + 3'(mem_rd)) < 3'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
      k        <= '0;
      win_base <= '0;
      win_cnt  <= '0;
      rd_tag   <= '0;
      ret_tag  <= '0;
      ret_vld  <= 1'b0;
    end else if (abort) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      mem_rd   <= 1'b0;
      ret_vld  <= 1'b0;
      k        <= '0;
      win_base <= '0;
      win_cnt  <= '0;
    end else begin
      mem_rd  <= issue;
      ret_vld <= mem_rd;
      ret_tag <= rd_tag;
      if (issue) begin
        mem_addr          <= win_base + k;
        rd_tag.win_last   <= (k == ADDR_W'(KERNEL - 1));
        rd_tag.frame_last <= last_issue;
        rd_tag.win_idx    <= win_cnt;
        if (k == ADDR_W'(KERNEL - 1)) begin
          k        <= '0;
          win_base <= win_base + ADDR_W'(STRIDE);
          win_cnt  <= win_cnt + 1'b1;
        end else begin
          k <= k + 1'b1;
        end
      end
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (issue) begin
            state <= last_issue ? DRAIN : FETCH;
            busy  <= 1'b1;
          end
        end
        FETCH: begin
          if (issue && last_issue) state <= DRAIN;
        end
        DRAIN: begin
          if (hs && out_frame_last) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            k        <= '0;
            win_base <= '0;
            win_cnt  <= '0;
          end
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
